// File: rtl/cim_xbar_responder_if.sv
// rtl/cim_xbar_responder_if.sv - layer-controller to crossbar-tile handshake bundle
interface cim_xbar_responder_if #(
  parameter int xbar_size     = 256,
  parameter int datatype_size = 4
);
  localparam int ADDR_W = $clog2(xbar_size);

  // Input-vector write port (layer's o_cim_wr_addr / o_cim_data)
  logic                     i_we;
  logic [ADDR_W-1:0]        i_wr_addr;
  logic [datatype_size-1:0] i_wr_data;

  // Weight programming port
  logic                     i_wgt_we;
  logic [ADDR_W-1:0]        i_wgt_row;
  logic [ADDR_W-1:0]        i_wgt_col;
  logic [datatype_size-1:0] i_wgt_data;

  // MVM control and status
  logic                     i_start;
  logic                     o_busy;
  logic                     o_done;

  // Result read port (layer's o_cim_rd_addr / i_data)
  logic [ADDR_W-1:0]        i_rd_addr;
  logic [datatype_size-1:0] o_data;

  // Layer side drives requests and samples status/results
  modport master (
    output i_we, i_wr_addr, i_wr_data,
    output i_wgt_we, i_wgt_row, i_wgt_col, i_wgt_data,
    output i_start, i_rd_addr,
    input  o_busy, o_done, o_data
  );

  // Tile side
  modport slave (
    input  i_we, i_wr_addr, i_wr_data,
    input  i_wgt_we, i_wgt_row, i_wgt_col, i_wgt_data,
    input  i_start, i_rd_addr,
    output o_busy, o_done, o_data
  );
endinterface

// File: rtl/cim_xbar_responder.sv
// rtl/cim_xbar_responder.sv - behavioural crossbar tile: latch vector, row-serial MVM, quantised column reads (CIM_XBAR_SAT_EN selects saturating quantise)
module cim_xbar_responder #(
  parameter int xbar_size     = 256,
  parameter int datatype_size = 4,
  parameter int out_shift     = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  cim_xbar_responder_if.slave  bus
);
  localparam int ADDR_W = $clog2(xbar_size);
  // Sum of xbar_size products of two datatype_size values cannot exceed this width
  localparam int ACC_W  = 2 * datatype_size + ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(xbar_size - 1);
`ifdef CIM_XBAR_SAT_EN
  localparam logic [ACC_W-1:0] OUT_MAX = ACC_W'((1 << datatype_size) - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_MAC,
    S_DONE
  } state_t;

  state_t                   r_state;
  state_t                   w_next_state;
  logic                     w_busy;
  logic                     w_done;
  logic                     w_wr_en;
  logic                     w_wgt_en;
  logic                     w_clear;
  logic                     w_mac;

  logic [ADDR_W-1:0]        r_row;
  logic [datatype_size-1:0] r_in  [xbar_size];
  logic [datatype_size-1:0] r_wgt [xbar_size][xbar_size];
  logic [ACC_W-1:0]         r_acc [xbar_size];
  logic [datatype_size-1:0] r_res [xbar_size];
  logic [datatype_size-1:0] r_data;

  // Shift the accumulator down, then either clip to all-ones or keep the low bits
  function automatic logic [datatype_size-1:0] quantise(input logic [ACC_W-1:0] acc);
`ifdef CIM_XBAR_SAT_EN
    if ((acc >> out_shift) > OUT_MAX) return '1;
`endif
    return datatype_size'(acc >> out_shift);
  endfunction

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  // Next state and control strobes; writes and start only count while idle
  always_comb begin
    w_next_state = r_state;
    w_busy       = 1'b1;
    w_done       = 1'b0;
    w_wr_en      = 1'b0;
    w_wgt_en     = 1'b0;
    w_clear      = 1'b0;
    w_mac        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy   = 1'b0;
        w_wr_en  = bus.i_we;
        w_wgt_en = bus.i_wgt_we;
        if (bus.i_start) w_next_state = S_CLEAR;
      end
      S_CLEAR: begin
        w_clear      = 1'b1;
        w_next_state = S_MAC;
      end
      S_MAC: begin
        w_mac = 1'b1;
        if (r_row == LAST_ROW) w_next_state = S_DONE;
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Input vector; a write coinciding with start lands before the first MAC row
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < xbar_size; i++) r_in[i] <= '0;
    end else if (w_wr_en) begin
      r_in[bus.i_wr_addr] <= bus.i_wr_data;
    end
  end

  // Weight array has no reset so a programmed tile survives a reset
  always_ff @(posedge clk) begin
    if (w_wgt_en) r_wgt[bus.i_wgt_row][bus.i_wgt_col] <= bus.i_wgt_data;
  end

  // Row counter and per-column accumulators: clear, then one crossbar row per cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row <= '0;
      for (int c = 0; c < xbar_size; c++) r_acc[c] <= '0;
    end else if (w_clear) begin
      r_row <= '0;
      for (int c = 0; c < xbar_size; c++) r_acc[c] <= '0;
    end else if (w_mac) begin
      r_row <= r_row + 1'b1;
      for (int c = 0; c < xbar_size; c++) begin
        r_acc[c] <= r_acc[c] + ACC_W'(r_in[r_row]) * ACC_W'(r_wgt[r_row][c]);
      end
    end
  end

  // Commit quantised results in the DONE cycle; they hold until the next MVM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < xbar_size; c++) r_res[c] <= '0;
    end else if (w_done) begin
      for (int c = 0; c < xbar_size; c++) r_res[c] <= quantise(r_acc[c]);
    end
  end

  // Registered read port, served in every state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_data <= '0;
    else      r_data <= r_res[bus.i_rd_addr];
  end

  assign bus.o_busy = w_busy;
  assign bus.o_done = w_done;
  assign bus.o_data = r_data;
endmodule

// File: tb/tb_cim_xbar_responder.sv
// tb/tb_cim_xbar_responder.sv - randomized self-checking bench for cim_xbar_responder
module tb_cim_xbar_responder;
  localparam int N    = 256;
  localparam int D    = 4;
  localparam int NDUT = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       d_we       [NDUT];
  logic [7:0] d_wr_addr  [NDUT];
  logic [3:0] d_wr_data  [NDUT];
  logic       d_wgt_we   [NDUT];
  logic [7:0] d_wgt_row  [NDUT];
  logic [7:0] d_wgt_col  [NDUT];
  logic [3:0] d_wgt_data [NDUT];
  logic       d_start    [NDUT];
  logic [7:0] d_rd_addr  [NDUT];
  logic       q_busy     [NDUT];
  logic       q_done     [NDUT];
  logic [3:0] q_data     [NDUT];

  cim_xbar_responder_if #(.xbar_size(N), .datatype_size(D)) u_if [NDUT] ();

  for (genvar k = 0; k < NDUT; k++) begin : g_bus
    assign u_if[k].i_we       = d_we[k];
    assign u_if[k].i_wr_addr  = d_wr_addr[k];
    assign u_if[k].i_wr_data  = d_wr_data[k];
    assign u_if[k].i_wgt_we   = d_wgt_we[k];
    assign u_if[k].i_wgt_row  = d_wgt_row[k];
    assign u_if[k].i_wgt_col  = d_wgt_col[k];
    assign u_if[k].i_wgt_data = d_wgt_data[k];
    assign u_if[k].i_start    = d_start[k];
    assign u_if[k].i_rd_addr  = d_rd_addr[k];
    assign q_busy[k]          = u_if[k].o_busy;
    assign q_done[k]          = u_if[k].o_done;
    assign q_data[k]          = u_if[k].o_data;
  end

  // Tile 0: all-ones weights; tile 1: identity; tile 2: identity with out_shift 2
  cim_xbar_responder #(.xbar_size(N), .datatype_size(D), .out_shift(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(u_if[0]));
  cim_xbar_responder #(.xbar_size(N), .datatype_size(D), .out_shift(0)) u_dut1 (
    .clk(clk), .rst(rst), .bus(u_if[1]));
  cim_xbar_responder #(.xbar_size(N), .datatype_size(D), .out_shift(2)) u_dut2 (
    .clk(clk), .rst(rst), .bus(u_if[2]));

  int m_w   [NDUT][N][N];
  int m_in  [NDUT][N];
  int m_res [NDUT][N];
  bit m_busy[NDUT];

  int checks   = 0;
  int failures = 0;

  function automatic int shift_of(input int k);
    return (k == 2) ? 2 : 0;
  endfunction

  function automatic int quant(input int acc, input int sh);
    int v;
    v = acc >> sh;
`ifdef CIM_XBAR_SAT_EN
    return (v > 15) ? 15 : v;
`else
    return v % 16;
`endif
  endfunction

  task automatic model_mvm(input int k);
    int sum;
    for (int c = 0; c < N; c++) begin
      sum = 0;
      for (int r = 0; r < N; r++) sum += m_in[k][r] * m_w[k][r][c];
      m_res[k][c] = quant(sum, shift_of(k));
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NDUT; k++) begin
      m_busy[k] = 1'b0;
      for (int i = 0; i < N; i++) begin
        m_in[k][i]  = 0;
        m_res[k][i] = 0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int k = 0; k < NDUT; k++) begin
      d_we[k]     = 1'b0;
      d_wgt_we[k] = 1'b0;
      d_start[k]  = 1'b0;
    end
  endtask

  task automatic drive_in(input int k, input int a, input int v);
    d_we[k]      = 1'b1;
    d_wr_addr[k] = a[7:0];
    d_wr_data[k] = v[3:0];
    if (!m_busy[k]) m_in[k][a] = v;
  endtask

  task automatic drive_wgt(input int k, input int r, input int c, input int v);
    d_wgt_we[k]   = 1'b1;
    d_wgt_row[k]  = r[7:0];
    d_wgt_col[k]  = c[7:0];
    d_wgt_data[k] = v[3:0];
    if (!m_busy[k]) m_w[k][r][c] = v;
  endtask

  // Start the masked tiles, watch busy/done over a bounded window, update the model
  task automatic run_mvm(input logic [NDUT-1:0] mask, input bit busy_poke, input bit watch_read);
    int busy_len [NDUT];
    int done_at  [NDUT];
    int done_cnt [NDUT];
    int old_val;
    int exp_val;
    for (int k = 0; k < NDUT; k++) begin
      busy_len[k] = 0;
      done_at[k]  = -1;
      done_cnt[k] = 0;
      d_start[k]  = mask[k];
    end
    old_val = m_res[1][0];
    tick();
    for (int k = 0; k < NDUT; k++) begin
      d_start[k]  = 1'b0;
      d_we[k]     = 1'b0;
      d_wgt_we[k] = 1'b0;
      if (mask[k]) m_busy[k] = 1'b1;
    end
    for (int n = 1; n <= N + 8; n++) begin
      for (int k = 0; k < NDUT; k++) begin
        if (q_busy[k] === 1'b1) busy_len[k]++;
        if (q_done[k] === 1'b1) begin
          done_cnt[k]++;
          if (done_at[k] < 0) done_at[k] = n;
        end
      end
      if (watch_read) begin
        exp_val = (n <= N + 3) ? old_val : m_res[1][0];
        check($sformatf("busy_read_n%0d", n), q_data[1], exp_val);
      end
      if (n == N + 2) begin
        for (int k = 0; k < NDUT; k++) if (mask[k]) model_mvm(k);
      end
      if (n == N + 3) begin
        for (int k = 0; k < NDUT; k++) if (mask[k]) m_busy[k] = 1'b0;
      end
      if (busy_poke && n == 10) begin
        drive_in(2, 3, 7);
        d_start[2] = 1'b1;
      end
      tick();
      d_we[2]    = 1'b0;
      d_start[2] = 1'b0;
    end
    for (int k = 0; k < NDUT; k++) begin
      if (mask[k]) begin
        check($sformatf("busy_len_d%0d", k), busy_len[k], N + 2);
        check($sformatf("done_at_d%0d", k), done_at[k], N + 2);
        check($sformatf("done_cnt_d%0d", k), done_cnt[k], 1);
      end
    end
  endtask

  task automatic read_all_cols(input string tag);
    for (int c = 0; c < N; c++) begin
      for (int k = 0; k < NDUT; k++) d_rd_addr[k] = c[7:0];
      tick();
      for (int k = 0; k < NDUT; k++)
        check($sformatf("%s_d%0d_c%0d", tag, k, c), q_data[k], m_res[k][c]);
    end
  endtask

  task automatic random_load();
    for (int r = 0; r < N; r++) begin
      for (int k = 0; k < NDUT; k++) begin
        drive_in(k, r, $urandom_range(0, 15));
        if (r < 48) drive_wgt(k, $urandom_range(0, N - 1), $urandom_range(0, N - 1), $urandom_range(0, 15));
        else d_wgt_we[k] = 1'b0;
      end
      tick();
    end
    idle_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_sat;
    for (int k = 0; k < NDUT; k++) begin
      d_wr_addr[k]  = '0;
      d_wr_data[k]  = '0;
      d_wgt_row[k]  = '0;
      d_wgt_col[k]  = '0;
      d_wgt_data[k] = '0;
      d_rd_addr[k]  = '0;
    end
    idle_all();
    model_reset();
    rst = 1'b0;
    repeat (3) tick();
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("rst_busy_d%0d", k), q_busy[k], 0);
      check($sformatf("rst_done_d%0d", k), q_done[k], 0);
      check($sformatf("rst_data_d%0d", k), q_data[k], 0);
    end
    #2 rst = 1'b1;
    tick();

    // Program weights on all three tiles in parallel
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        drive_wgt(0, r, c, 1);
        drive_wgt(1, r, c, (r == c) ? 1 : 0);
        drive_wgt(2, r, c, (r == c) ? 1 : 0);
        tick();
      end
    end
    idle_all();

    // Inputs: tile 0 all ones, tile 1 r mod 16, tile 2 only in[3]=15
    for (int r = 0; r < N; r++) begin
      drive_in(0, r, 1);
      drive_in(1, r, r % 16);
      if (r == 3) drive_in(2, 3, 15);
      else d_we[2] = 1'b0;
      tick();
    end
    idle_all();
    run_mvm(3'b111, 1'b0, 1'b0);

`ifdef CIM_XBAR_SAT_EN
    exp_sat = 15;
`else
    exp_sat = 0;
`endif
    d_rd_addr[0] = 8'd0;
    d_rd_addr[1] = 8'd37;
    d_rd_addr[2] = 8'd3;
    tick();
    check("ones_col0", q_data[0], exp_sat);
    check("ident_col37", q_data[1], 5);
    check("shift2_col3", q_data[2], 3);
    d_rd_addr[2] = 8'd4;
    tick();
    check("shift2_col4", q_data[2], 0);

    // Second MVM: tile 2 gets a write and start while busy; tile 1 is read during busy
    drive_in(1, 0, 9);
    tick();
    idle_all();
    d_rd_addr[1] = 8'd0;
    d_rd_addr[2] = 8'd3;
    run_mvm(3'b110, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("no_extra_mvm_%0d", i), q_busy[2], 0);
      tick();
    end
    check("after_busy_write_col3", q_data[2], 3);
    check("read_new_col0", q_data[1], 9);
    run_mvm(3'b100, 1'b0, 1'b0);
    tick();
    check("rerun_col3", q_data[2], 3);

    // Randomized rounds against the model
    for (int round = 0; round < 2; round++) begin
      random_load();
      run_mvm(3'b111, 1'b0, 1'b0);
      read_all_cols($sformatf("rand%0d", round));
    end

    // Reset at MAC row 100
    for (int k = 0; k < NDUT; k++) begin
      d_start[k]   = 1'b1;
      d_rd_addr[k] = 8'd1;
    end
    tick();
    idle_all();
    repeat (101) tick();
    for (int k = 0; k < NDUT; k++) check($sformatf("pre_rst_busy_d%0d", k), q_busy[k], 1);
    #2 rst = 1'b0;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("midrst_busy_d%0d", k), q_busy[k], 0);
      check($sformatf("midrst_done_d%0d", k), q_done[k], 0);
      check($sformatf("midrst_data_d%0d", k), q_data[k], 0);
    end
    model_reset();
    tick();
    tick();
    #2 rst = 1'b1;
    tick();
    for (int k = 0; k < NDUT; k++) d_rd_addr[k] = 8'd7;
    tick();
    for (int k = 0; k < NDUT; k++) check($sformatf("post_rst_read_d%0d", k), q_data[k], 0);

    // Fresh MVM with retained weights
    for (int r = 0; r < N; r++) begin
      drive_in(0, r, 1);
      drive_in(1, r, $urandom_range(0, 15));
      drive_in(2, r, $urandom_range(0, 15));
      tick();
    end
    idle_all();
    run_mvm(3'b111, 1'b0, 1'b0);
    read_all_cols("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
